// File: rtl/modos_multicanal.sv
// Multi-channel need tracker: per-channel press-and-hold qualifiers, decaying/refilling
// saturating levels with critical flags, and a held-button general reset pulse.

module modos_multicanal_hold #(
    parameter int CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(CYC + 1);
    localparam logic [CW-1:0] CYC_V = CW'(CYC);

    typedef enum logic [1:0] {IDLE, COUNT, FIRED} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          pulse_d;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= pulse_d;
        end
    end

    // IDLE restarts the run at 1 so the first high sample already counts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        cnt_inc = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
        case (state_q)
            IDLE, COUNT: begin
                if (btn) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CYC_V) begin
                        state_d = FIRED;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = COUNT;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            FIRED: begin
                if (!btn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

module modos_multicanal #(
    parameter int N_CH         = 4,
    parameter int LVL_W        = 3,
    parameter int HOLD_CYC     = 250_000_000,
    parameter int RST_HOLD_CYC = 250_000_000,
    parameter int DECAY_CYC    = 1_000_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bot_reset,
    input  logic [N_CH-1:0]       bot,
    input  logic [N_CH-1:0]       activo,
    output logic [N_CH-1:0]       hold_pulse,
    output logic                  reset_general,
    output logic [N_CH*LVL_W-1:0] nivel,
    output logic [N_CH-1:0]       critico
);
    localparam logic [LVL_W-1:0] LVL_MAX  = '1;
    localparam int               PW       = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(DECAY_CYC - 1);

    logic [PW-1:0]                pre_q;
    logic                         tick;
    logic [N_CH-1:0]              activo_q, inc;
    logic [N_CH-1:0][LVL_W-1:0]   lvl_q;

    modos_multicanal_hold #(.CYC(RST_HOLD_CYC)) u_rst_hold (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .btn   (bot_reset),
        .pulse (reset_general)
    );

    assign tick = (pre_q == PRE_LAST);
    assign inc  = activo & ~activo_q;

    // reset_general acts as a soft reload of everything except its own qualifier
    always_ff @(posedge clk) begin
        if (reset || reset_general) begin
            pre_q    <= '0;
            activo_q <= '0;
        end else begin
            pre_q    <= tick ? '0 : pre_q + PW'(1);
            activo_q <= activo;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        modos_multicanal_hold #(.CYC(HOLD_CYC)) u_hold (
            .clk   (clk),
            .reset (reset),
            .clear (reset_general),
            .btn   (bot[g]),
            .pulse (hold_pulse[g])
        );

        // refill and decay landing together cancel out
        always_ff @(posedge clk) begin
            if (reset || reset_general)
                lvl_q[g] <= LVL_MAX;
            else if (inc[g] && !tick && lvl_q[g] != LVL_MAX)
                lvl_q[g] <= lvl_q[g] + LVL_W'(1);
            else if (tick && !inc[g] && lvl_q[g] != '0)
                lvl_q[g] <= lvl_q[g] - LVL_W'(1);
        end

        assign critico[g] = (lvl_q[g] == '0);
    end

    assign nivel = lvl_q;
endmodule
